// File: rtl/pip_divider.sv
// Pipelined unsigned restoring divider: 2W-bit dividend / W-bit divisor.
// One operation accepted per cycle; result appears W+1 cycles after the
// input is registered. Divide-by-zero and quotient-overflow are flagged.
module pip_divider #(
    parameter int unsigned W = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    input  logic [2*W-1:0] dividend,
    input  logic [W-1:0]   divisor,
    output logic           out_valid,
    output logic [W-1:0]   quotient,
    output logic [W-1:0]   remainder,
    output logic           div_by_zero,
    output logic           overflow
);

    // Stage 0 holds the registered inputs; stages 1..W each hold one more
    // resolved quotient bit. Divisor and remaining dividend bits are only
    // needed up to stage W-1.
    logic         vld_q [0:W];
    logic         vld_d [0:W];
    logic         dz_q  [0:W];
    logic         dz_d  [0:W];
    logic         ov_q  [0:W];
    logic         ov_d  [0:W];
    logic [W-1:0] rem_q [0:W];
    logic [W-1:0] rem_d [0:W];
    logic [W-1:0] quo_q [0:W];
    logic [W-1:0] quo_d [0:W];
    logic [W-1:0] dvs_q [0:W-1];
    logic [W-1:0] dvs_d [0:W-1];
    logic [W-1:0] lo_q  [0:W-1];
    logic [W-1:0] lo_d  [0:W-1];

    logic         out_valid_q;
    logic [W-1:0] quotient_q;
    logic [W-1:0] remainder_q;
    logic         div_by_zero_q;
    logic         overflow_q;

    // Next-state for every pipeline stage: input capture, then one
    // restoring shift/compare/subtract step per stage.
    always_comb begin : stage_next
        logic [W:0] trial;
        logic [W:0] diff;
        logic       qbit;
        trial = '0;
        diff  = '0;
        qbit  = 1'b0;

        vld_d[0] = in_valid;
        dz_d[0]  = (divisor == '0);
        ov_d[0]  = (divisor != '0) && (dividend[2*W-1:W] >= divisor);
        rem_d[0] = dividend[2*W-1:W];
        quo_d[0] = '0;
        dvs_d[0] = divisor;
        lo_d[0]  = dividend[W-1:0];

        // With divisor 0 every compare succeeds and nothing is subtracted, so
        // the partial remainder simply shifts in the low dividend half and the
        // quotient fills with ones: the divide-by-zero result needs no override.
        for (int unsigned k = 1; k <= W; k++) begin
            trial = {rem_q[k-1], lo_q[k-1][W-1]};
            if (trial >= {1'b0, dvs_q[k-1]}) begin
                diff     = trial - {1'b0, dvs_q[k-1]};
                rem_d[k] = diff[W-1:0];
                qbit     = 1'b1;
            end else begin
                rem_d[k] = trial[W-1:0];
                qbit     = 1'b0;
            end
            quo_d[k] = {quo_q[k-1][W-2:0], qbit};
            vld_d[k] = vld_q[k-1];
            dz_d[k]  = dz_q[k-1];
            ov_d[k]  = ov_q[k-1];
        end

        for (int unsigned k = 1; k < W; k++) begin
            dvs_d[k] = dvs_q[k-1];
            lo_d[k]  = {lo_q[k-1][W-2:0], 1'b0};
        end
    end

    // Pipeline registers: only the valid bits are reset.
    always_ff @(posedge clk) begin
        for (int unsigned k = 0; k <= W; k++) begin
            dz_q[k]  <= dz_d[k];
            ov_q[k]  <= ov_d[k];
            rem_q[k] <= rem_d[k];
            quo_q[k] <= quo_d[k];
        end
        for (int unsigned k = 0; k < W; k++) begin
            dvs_q[k] <= dvs_d[k];
            lo_q[k]  <= lo_d[k];
        end
        for (int unsigned k = 0; k <= W; k++) begin
            vld_q[k] <= rst ? 1'b0 : vld_d[k];
        end
    end

    // Output register: loads on a valid final stage, holds through bubbles.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q   <= 1'b0;
            quotient_q    <= '0;
            remainder_q   <= '0;
            div_by_zero_q <= 1'b0;
            overflow_q    <= 1'b0;
        end else begin
            out_valid_q <= vld_q[W];
            if (vld_q[W]) begin
                quotient_q    <= ov_q[W] ? '1 : quo_q[W];
                remainder_q   <= ov_q[W] ? '0 : rem_q[W];
                div_by_zero_q <= dz_q[W];
                overflow_q    <= ov_q[W];
            end
        end
    end

    assign out_valid   = out_valid_q;
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = div_by_zero_q;
    assign overflow    = overflow_q;

endmodule

// File: tb/tb_pip_divider.sv
// Self-checking bench for pip_divider: directed table, reset-in-flight
// sequence and a randomized sweep against an arithmetic reference model.
module tb_pip_divider;

    localparam int unsigned W   = 8;
    localparam int          LAT = W + 1;

    logic           clk;
    logic           rst;
    logic           in_valid;
    logic [2*W-1:0] dividend;
    logic [W-1:0]   divisor;
    logic           out_valid;
    logic [W-1:0]   quotient;
    logic [W-1:0]   remainder;
    logic           div_by_zero;
    logic           overflow;

    pip_divider #(.W(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .dividend    (dividend),
        .divisor     (divisor),
        .out_valid   (out_valid),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero),
        .overflow    (overflow)
    );

    typedef struct {
        bit          vld;
        logic [15:0] a;
        logic [7:0]  b;
        logic [7:0]  q;
        logic [7:0]  r;
        bit          dz;
        bit          ov;
    } vec_t;

    typedef struct {
        int         due;
        logic [7:0] q;
        logic [7:0] r;
        bit         dz;
        bit         ov;
    } exp_t;

    exp_t        sbq[$];
    logic [17:0] hold_v;
    int          cyc;
    int          n_cmp;
    int          n_err;
    string       tag;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference: plain integer division with the flag rules applied on top.
    function automatic exp_t model(input logic [15:0] a, input logic [7:0] b);
        exp_t        e;
        int unsigned qa;
        e.due = 0;
        if (b == 0) begin
            e.q = 8'hFF; e.r = a[7:0]; e.dz = 1'b1; e.ov = 1'b0;
        end else begin
            qa = int'(a) / int'(b);
            if (qa > 255) begin
                e.q = 8'hFF; e.r = 8'h00; e.dz = 1'b0; e.ov = 1'b1;
            end else begin
                e.q = 8'(qa); e.r = 8'(int'(a) % int'(b)); e.dz = 1'b0; e.ov = 1'b0;
            end
        end
        return e;
    endfunction

    task automatic check_out();
        exp_t        e;
        logic [18:0] expv;
        logic [18:0] got;
        if (sbq.size() > 0 && sbq[0].due == cyc) begin
            e      = sbq.pop_front();
            hold_v = {e.q, e.r, e.dz, e.ov};
            expv   = {1'b1, hold_v};
        end else begin
            expv = {1'b0, hold_v};
        end
        got = {out_valid, quotient, remainder, div_by_zero, overflow};
        n_cmp++;
        if (got !== expv) begin
            n_err++;
            $display("FAIL %s cyc=%0d got v=%b q=%0d r=%0d dz=%b ov=%b required v=%b q=%0d r=%0d dz=%b ov=%b",
                     tag, cyc, got[18], got[17:10], got[9:2], got[1], got[0],
                     expv[18], expv[17:10], expv[9:2], expv[1], expv[0]);
        end
    endtask

    task automatic step(input bit v, input logic [15:0] a, input logic [7:0] b,
                        input logic [7:0] eq, input logic [7:0] er, input bit edz, input bit eov);
        exp_t e;
        @(negedge clk);
        check_out();
        in_valid = v;
        dividend = a;
        divisor  = b;
        if (v) begin
            e.due = cyc + 1 + LAT;
            e.q = eq; e.r = er; e.dz = edz; e.ov = eov;
            sbq.push_back(e);
        end
    endtask

    task automatic step_model(input bit v, input logic [15:0] a, input logic [7:0] b);
        exp_t e;
        e = model(a, b);
        step(v, a, b, e.q, e.r, e.dz, e.ov);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 16'h0, 8'h0, 8'h0, 8'h0, 1'b0, 1'b0);
    endtask

    // Reset held for n cycles; in_valid is driven high throughout to show it is ignored.
    task automatic do_reset(input int n);
        @(negedge clk);
        check_out();
        rst      = 1'b1;
        in_valid = 1'b1;
        dividend = 16'd600;
        divisor  = 8'd6;
        sbq.delete();
        hold_v = '0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check_out();
        end
        rst      = 1'b0;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < LAT + 4 && sbq.size() > 0; i++) idle(1);
        n_cmp++;
        if (sbq.size() != 0) begin
            n_err++;
            $display("FAIL %s drain timeout: %0d results outstanding, required 0", tag, sbq.size());
            sbq.delete();
        end
        idle(2);
    endtask

    vec_t tbl[$];

    initial begin
        logic [15:0] a;
        logic [7:0]  b;
        bit          v;

        rst = 1'b1; in_valid = 1'b0; dividend = '0; divisor = '0;
        cyc = 0; n_cmp = 0; n_err = 0; hold_v = '0;

        tag = "reset";
        do_reset(3);
        idle(2);

        tbl = '{
            '{1'b1, 16'd91,    8'd7,   8'd13,  8'd0,   1'b0, 1'b0},
            '{1'b0, 16'd0,     8'd0,   8'd0,   8'd0,   1'b0, 1'b0},
            '{1'b0, 16'd0,     8'd0,   8'd0,   8'd0,   1'b0, 1'b0},
            '{1'b1, 16'd65025, 8'd255, 8'd255, 8'd0,   1'b0, 1'b0},
            '{1'b1, 16'd200,   8'd7,   8'd28,  8'd4,   1'b0, 1'b0},
            '{1'b1, 16'd0,     8'd123, 8'd0,   8'd0,   1'b0, 1'b0},
            '{1'b1, 16'd256,   8'd2,   8'd128, 8'd0,   1'b0, 1'b0},
            '{1'b0, 16'd0,     8'd0,   8'd0,   8'd0,   1'b0, 1'b0},
            '{1'b1, 16'd100,   8'd0,   8'd255, 8'd100, 1'b1, 1'b0},
            '{1'b0, 16'd0,     8'd0,   8'd0,   8'd0,   1'b0, 1'b0},
            '{1'b1, 16'd256,   8'd1,   8'd255, 8'd0,   1'b0, 1'b1},
            '{1'b1, 16'd65535, 8'd255, 8'd255, 8'd0,   1'b0, 1'b1},
            '{1'b0, 16'd0,     8'd0,   8'd0,   8'd0,   1'b0, 1'b0},
            '{1'b1, 16'd91,    8'd7,   8'd13,  8'd0,   1'b0, 1'b0},
            '{1'b0, 16'd0,     8'd0,   8'd0,   8'd0,   1'b0, 1'b0},
            '{1'b1, 16'd256,   8'd2,   8'd128, 8'd0,   1'b0, 1'b0}
        };
        tag = "table";
        foreach (tbl[i]) step(tbl[i].vld, tbl[i].a, tbl[i].b, tbl[i].q, tbl[i].r, tbl[i].dz, tbl[i].ov);
        drain();

        tag = "rst_inflight";
        step(1'b1, 16'd1000, 8'd9, 8'd111, 8'd1, 1'b0, 1'b0);
        step(1'b1, 16'd500,  8'd3, 8'd166, 8'd2, 1'b0, 1'b0);
        step(1'b1, 16'd77,   8'd7, 8'd11,  8'd0, 1'b0, 1'b0);
        idle(1);
        do_reset(1);
        idle(LAT + 3);
        tag = "post_rst";
        step(1'b1, 16'd50, 8'd5, 8'd10, 8'd0, 1'b0, 1'b0);
        drain();

        tag = "random";
        for (int i = 0; i < 10000; i++) begin
            case ($urandom_range(0, 5))
                0:       b = 8'd0;
                1:       b = 8'd1;
                2:       b = 8'd255;
                default: b = 8'($urandom_range(1, 255));
            endcase
            case ($urandom_range(0, 4))
                0:       a = 16'h0000;
                1:       a = 16'hFFFF;
                2:       a = 16'($urandom);
                default: a = (b == 0) ? 16'($urandom)
                                      : 16'($urandom_range(0, 255) * int'(b) + $urandom_range(0, int'(b) - 1));
            endcase
            v = ($urandom_range(0, 9) != 0);
            step_model(v, a, b);
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
